axis_frame_gen: RTL and testbench

AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

---
 rtl/axis_frame_gen.sv | 139 +++++++++++++
 tb/tb_axis_frame_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_gen.sv
// AXI4-Stream frame generator for an Aurora TX link: emits fixed-length frames of an
// incrementing data pattern, separated by idle gaps, for a programmable number of frames.
module axis_frame_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 19,
    parameter int NUM_FRAMES = 3,
    parameter int DATA_INC   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    tx_channel_up,
    input  logic                    s_axi_tx_tready,
    output logic [DATA_WIDTH-1:0]   s_axi_tx_tdata,
    output logic [DATA_WIDTH/8-1:0] s_axi_tx_tkeep,
    output logic                    s_axi_tx_tlast,
    output logic                    s_axi_tx_tvalid,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             frame_count
);

    localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [3:0]            LAST_GAP  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [15:0]           FRAMES    = 16'(NUM_FRAMES);
    localparam logic [DATA_WIDTH-1:0] INC       = DATA_WIDTH'(DATA_INC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [3:0]              gap_q, gap_d;
    logic                    accept;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d       = state_q;
        tdata_d       = tdata_q;
        frame_count_d = frame_count_q;
        beat_d        = beat_q;
        gap_d         = gap_q;
        accept        = tvalid_q & s_axi_tx_tready;

        unique case (state_q)
            ST_IDLE: begin
                if (start && tx_channel_up) begin
                    state_d       = ST_SEND;
                    tdata_d       = '0;
                    frame_count_d = '0;
                    beat_d        = '0;
                end
            end
            ST_SEND: begin
                // A link drop abandons the frame, even if the sink is taking the current beat.
                if (!tx_channel_up) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    tdata_d = tdata_q + INC;
                    if (beat_q == LAST_BEAT) begin
                        beat_d        = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        if (NUM_FRAMES != 0 && frame_count_d == FRAMES) begin
                            state_d = ST_DONE;
                        end else if (GAP_CYCLES > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (!tx_channel_up) begin
                    state_d = ST_IDLE;
                end else if (gap_q == LAST_GAP) begin
                    state_d = ST_SEND;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        tvalid_d = (state_d == ST_SEND);
        tlast_d  = (state_d == ST_SEND) && (beat_d == LAST_BEAT);
        busy_d   = (state_d == ST_SEND) || (state_d == ST_GAP);
        done_d   = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            tdata_q       <= '0;
            tlast_q       <= 1'b0;
            tvalid_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            frame_count_q <= '0;
            beat_q        <= '0;
            gap_q         <= '0;
        end else begin
            state_q       <= state_d;
            tdata_q       <= tdata_d;
            tlast_q       <= tlast_d;
            tvalid_q      <= tvalid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            frame_count_q <= frame_count_d;
            beat_q        <= beat_d;
            gap_q         <= gap_d;
        end
    end

    assign s_axi_tx_tdata  = tdata_q;
    assign s_axi_tx_tkeep  = '1;
    assign s_axi_tx_tlast  = tlast_q;
    assign s_axi_tx_tvalid = tvalid_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign frame_count     = frame_count_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen: three parameterisations run side by side,
// expected beat sequences held in tables, plus link-drop and async-reset sequences.
module tb_axis_frame_gen;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start23, tx_channel_up, tready1, tready_hi;

    logic [31:0] tdata1, tdata2;
    logic [7:0]  tdata3;
    logic [3:0]  tkeep1, tkeep2;
    logic [0:0]  tkeep3;
    logic        tlast1, tvalid1, busy1, done1;
    logic        tlast2, tvalid2, busy2, done2;
    logic        tlast3, tvalid3, busy3, done3;
    logic [15:0] fc1, fc2, fc3;

    axis_frame_gen u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_channel_up(tx_channel_up),
        .s_axi_tx_tready(tready1), .s_axi_tx_tdata(tdata1), .s_axi_tx_tkeep(tkeep1),
        .s_axi_tx_tlast(tlast1), .s_axi_tx_tvalid(tvalid1), .busy(busy1), .done(done1),
        .frame_count(fc1)
    );

    axis_frame_gen #(.FRAME_LEN(4), .NUM_FRAMES(2), .GAP_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start23), .tx_channel_up(tx_channel_up),
        .s_axi_tx_tready(tready_hi), .s_axi_tx_tdata(tdata2), .s_axi_tx_tkeep(tkeep2),
        .s_axi_tx_tlast(tlast2), .s_axi_tx_tvalid(tvalid2), .busy(busy2), .done(done2),
        .frame_count(fc2)
    );

    axis_frame_gen #(.DATA_WIDTH(8), .DATA_INC(64), .FRAME_LEN(6), .NUM_FRAMES(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start23), .tx_channel_up(tx_channel_up),
        .s_axi_tx_tready(tready_hi), .s_axi_tx_tdata(tdata3), .s_axi_tx_tkeep(tkeep3),
        .s_axi_tx_tlast(tlast3), .s_axi_tx_tvalid(tvalid3), .busy(busy3), .done(done3),
        .frame_count(fc3)
    );

    int total = 0;
    int bad   = 0;

    beat_t exp1[57];
    beat_t exp2[8];
    beat_t exp3[6];

    beat_t q1[$], q2[$], q3[$];
    int    gaps1[$];
    int    gap_run1, done_cnt1, valid_cnt1, stall_err1, low2, done_cnt2, done_cnt3;
    logic  prev_stall1, prev_last1;
    logic [31:0] prev_data1;
    bit    rand_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string tag, input int i, input beat_t act, input beat_t exp);
        check($sformatf("%s[%0d]", tag, i), 64'(act), 64'(exp));
    endtask

    task automatic clear_mon();
        q1.delete(); q2.delete(); q3.delete(); gaps1.delete();
        gap_run1 = 0; done_cnt1 = 0; valid_cnt1 = 0; stall_err1 = 0;
        low2 = 0; done_cnt2 = 0; done_cnt3 = 0;
        prev_stall1 = 1'b0; prev_last1 = 1'b0; prev_data1 = '0;
    endtask

    // Samples at negedge+1: values seen here are what the next rising edge acts on.
    task automatic sample();
        if (tvalid1 && tready1) q1.push_back('{tdata1, tlast1});
        if (tvalid1) valid_cnt1++;
        if (prev_stall1 && tvalid1 && (tdata1 !== prev_data1 || tlast1 !== prev_last1)) stall_err1++;
        prev_stall1 = tvalid1 && !tready1;
        prev_data1  = tdata1;
        prev_last1  = tlast1;
        if (busy1 && !tvalid1) gap_run1++;
        else if (tvalid1 && gap_run1 != 0) begin
            gaps1.push_back(gap_run1);
            gap_run1 = 0;
        end
        if (done1) done_cnt1++;
        if (tvalid2 && tready_hi) q2.push_back('{tdata2, tlast2});
        if (busy2 && !tvalid2) low2++;
        if (done2) done_cnt2++;
        if (tvalid3 && tready_hi) q3.push_back('{{24'd0, tdata3}, tlast3});
        if (done3) done_cnt3++;
    endtask

    task automatic cycle();
        @(negedge clk);
        if (rand_ready) tready1 = 1'($urandom_range(0, 1));
        #1;
        sample();
    endtask

    task automatic run_frames(input bit rnd);
        clear_mon();
        rand_ready = rnd;
        tready1    = 1'b1;
        start = 1'b1; start23 = 1'b1;
        cycle();
        start = 1'b0; start23 = 1'b0;
        check("first_valid", 64'(tvalid1), 64'd1);
        check("first_data", 64'(tdata1), 64'd0);
        for (int c = 0; c < 1000 && done_cnt1 == 0; c++) begin
            cycle();
            start = (rnd && c == 30);
        end
        start = 1'b0;
        repeat (4) cycle();
        rand_ready = 1'b0;
        tready1    = 1'b1;

        check("d1_done_count", 64'(done_cnt1), 64'd1);
        check("d1_frame_count", 64'(fc1), 64'd3);
        check("d1_busy_after", 64'(busy1), 64'd0);
        check("d1_valid_after", 64'(tvalid1), 64'd0);
        check("d1_beats", 64'(q1.size()), 64'd57);
        for (int i = 0; i < q1.size() && i < 57; i++) check_beat("d1_beat", i, q1[i], exp1[i]);
        check("d1_gap_count", 64'(gaps1.size()), 64'd2);
        for (int i = 0; i < gaps1.size(); i++) check($sformatf("d1_gap[%0d]", i), 64'(gaps1[i]), 64'd2);
        if (rnd) check("d1_stall_stable", 64'(stall_err1), 64'd0);

        check("d2_beats", 64'(q2.size()), 64'd8);
        for (int i = 0; i < q2.size() && i < 8; i++) check_beat("d2_beat", i, q2[i], exp2[i]);
        check("d2_valid_low", 64'(low2), 64'd0);
        check("d2_done_count", 64'(done_cnt2), 64'd1);
        check("d2_frame_count", 64'(fc2), 64'd2);

        check("d3_beats", 64'(q3.size()), 64'd6);
        for (int i = 0; i < q3.size() && i < 6; i++) check_beat("d3_beat", i, q3[i], exp3[i]);
        check("d3_done_count", 64'(done_cnt3), 64'd1);
        check("d3_frame_count", 64'(fc3), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 57; i++) begin
            exp1[i].data = 32'(i * 4);
            exp1[i].last = (i % 19 == 18);
        end
        for (int i = 0; i < 8; i++) begin
            exp2[i].data = 32'(i * 4);
            exp2[i].last = (i % 4 == 3);
        end
        exp3[0] = '{32'd0,   1'b0};
        exp3[1] = '{32'd64,  1'b0};
        exp3[2] = '{32'd128, 1'b0};
        exp3[3] = '{32'd192, 1'b0};
        exp3[4] = '{32'd0,   1'b0};
        exp3[5] = '{32'd64,  1'b1};

        rst_n = 1'b0; start = 1'b0; start23 = 1'b0;
        tx_channel_up = 1'b1; tready1 = 1'b1; tready_hi = 1'b1; rand_ready = 1'b0;
        clear_mon();

        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", 64'(tvalid1), 64'd0);
        check("rst_tdata", 64'(tdata1), 64'd0);
        check("rst_tlast", 64'(tlast1), 64'd0);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_frame_count", 64'(fc1), 64'd0);
        rst_n = 1'b1;
        cycle();
        check("idle_tkeep", 64'(tkeep1), 64'hf);
        check("idle_tvalid", 64'(tvalid1), 64'd0);

        run_frames(1'b0);
        run_frames(1'b1);

        // Link drop partway through the second frame.
        clear_mon();
        start = 1'b1; start23 = 1'b1;
        cycle();
        start = 1'b0; start23 = 1'b0;
        for (int c = 0; c < 300 && q1.size() < 29; c++) cycle();
        check("drop_reached_beat", 64'(q1.size()), 64'd29);
        tx_channel_up = 1'b0;
        cycle();
        check("drop_tvalid", 64'(tvalid1), 64'd0);
        check("drop_busy", 64'(busy1), 64'd0);
        check("drop_frame_count", 64'(fc1), 64'd1);
        valid_cnt1 = 0;
        repeat (10) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (5) cycle();
        check("drop_no_valid", 64'(valid_cnt1), 64'd0);
        check("drop_no_done", 64'(done_cnt1), 64'd0);
        check("drop_start_ignored", 64'(busy1), 64'd0);
        check("drop_fc_holds", 64'(fc1), 64'd1);
        tx_channel_up = 1'b1;
        cycle();

        // Asynchronous reset in the middle of a frame.
        clear_mon();
        start = 1'b1; start23 = 1'b1;
        cycle();
        start = 1'b0; start23 = 1'b0;
        repeat (8) cycle();
        check("pre_reset_valid", 64'(tvalid1), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_tvalid", 64'(tvalid1), 64'd0);
        check("async_tdata", 64'(tdata1), 64'd0);
        check("async_tlast", 64'(tlast1), 64'd0);
        check("async_busy", 64'(busy1), 64'd0);
        check("async_frame_count", 64'(fc1), 64'd0);
        valid_cnt1 = 0;
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) cycle();
        check("post_reset_no_valid", 64'(valid_cnt1), 64'd0);
        check("post_reset_busy", 64'(busy1), 64'd0);

        run_frames(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
